// File: rtl/nor_gate.sv
// Bitwise NOR with a registered copy, an all-ones flag, a change pulse,
// and a saturating counter of captures where both operands were all-zero.
module nor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_all,
  output logic             chg,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic             y_and;
  logic [CNT_W-1:0] cnt_inc;

  assign y       = ~(a | b);
  assign y_and   = &y;
  assign cnt_inc = cnt + 1'b1;

  // Capture NOR result and flag; chg pulses only when a capture alters y_q.
  // Reset values match a = b = 0 so leaving reset idle gives no chg pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '1;
      y_all <= 1'b1;
      chg   <= 1'b0;
    end else if (en) begin
      y_q   <= y;
      y_all <= y_and;
      chg   <= (y != y_q);
    end else begin
      chg   <= 1'b0;
    end
  end

  // Saturating all-NOR event counter; clr wins over an increment, sat is sticky.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (en && y_and && !(&cnt)) begin
      cnt <= cnt_inc;
      sat <= sat | (&cnt_inc);
    end
  end

endmodule

// File: tb/tb_nor_gate.sv
// Bench for nor_gate: vector table plus hand sequences, expectations queued
// at drive time and compared one cycle later after the capturing edge.
module tb_nor_gate;
  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, en, clr;
  logic [W-1:0]  a, b;
  logic [W-1:0]  y, y_q;
  logic          y_all, chg, sat;
  logic [CW-1:0] cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          rst;
    logic          en;
    logic          clr;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  exp_y;
    logic [W-1:0]  exp_yq;
    logic          exp_all;
    logic          exp_chg;
    logic [CW-1:0] exp_cnt;
    logic          exp_sat;
    string         name;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[12];

  nor_gate #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .clr(clr),
    .y(y), .y_q(y_q), .y_all(y_all), .chg(chg), .cnt(cnt), .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got time %0t, required finish before 100000", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; en = v.en; clr = v.clr; a = v.a; b = v.b;
    #1;
    chk({v.name, ".y"}, 32'(y), 32'(v.exp_y));
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({e.name, ".y_q"},   32'(y_q),   32'(e.exp_yq));
    chk({e.name, ".y_all"}, 32'(y_all), 32'(e.exp_all));
    chk({e.name, ".chg"},   32'(chg),   32'(e.exp_chg));
    chk({e.name, ".cnt"},   32'(cnt),   32'(e.exp_cnt));
    chk({e.name, ".sat"},   32'(sat),   32'(e.exp_sat));
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic c,
                              input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [W-1:0] yq, input logic al, input logic ch,
                              input logic [CW-1:0] ct, input logic st, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.a = va; v.b = vb;
    v.exp_y = ~(va | vb);
    v.exp_yq = yq; v.exp_all = al; v.exp_chg = ch; v.exp_cnt = ct; v.exp_sat = st;
    v.name = nm;
    return v;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; a = '0; b = '0;

    //            rst en clr a      b      y_q    all chg cnt sat
    tbl[0]  = mk(1, 1, 1, 4'h1, 4'h0, 4'hF, 1, 0, 0, 0, "rst_over_en_clr");
    tbl[1]  = mk(0, 1, 0, 4'h0, 4'h0, 4'hF, 1, 0, 1, 0, "leave_rst_idle");
    tbl[2]  = mk(0, 1, 0, 4'h0, 4'h1, 4'hE, 0, 1, 1, 0, "a0_b1_capture");
    tbl[3]  = mk(0, 1, 0, 4'h0, 4'h1, 4'hE, 0, 0, 1, 0, "a0_b1_held");
    tbl[4]  = mk(0, 1, 0, 4'h5, 4'h3, 4'h8, 0, 1, 1, 0, "truth_table_bits");
    tbl[5]  = mk(0, 0, 0, 4'h5, 4'h3, 4'h8, 0, 0, 1, 0, "en0_hold");
    tbl[6]  = mk(0, 0, 0, 4'h0, 4'h0, 4'h8, 0, 0, 1, 0, "en0_y_comb");
    tbl[7]  = mk(0, 1, 0, 4'h0, 4'h0, 4'hF, 1, 1, 2, 0, "all_zero_capture");
    tbl[8]  = mk(0, 1, 1, 4'h0, 4'h0, 4'hF, 1, 0, 0, 0, "clr_beats_inc");
    tbl[9]  = mk(0, 1, 0, 4'hA, 4'h0, 4'h5, 0, 1, 0, 0, "a_A_capture");
    tbl[10] = mk(0, 1, 0, 4'hF, 4'hF, 4'h0, 0, 1, 0, 0, "ones_capture");
    tbl[11] = mk(1, 1, 0, 4'h0, 4'h0, 4'hF, 1, 0, 0, 0, "rst_discards_capture");

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // Five idle captures after reset, then hold with en low.
    for (int i = 1; i <= 5; i++)
      apply(mk(0, 1, 0, 4'h0, 4'h0, 4'hF, 1, 0, CW'(i), 0, $sformatf("count5_%0d", i)));
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 4'h0, 4'h0, 4'hF, 1, 0, 5, 0, $sformatf("count5_hold_%0d", i)));

    // Saturation: 20 captures from zero stop at 15 with sat from the 15th.
    apply(mk(0, 1, 1, 4'h0, 4'h0, 4'hF, 1, 0, 0, 0, "sat_pre_clr"));
    for (int i = 1; i <= 20; i++)
      apply(mk(0, 1, 0, 4'h0, 4'h0, 4'hF, 1, 0, CW'((i > 15) ? 15 : i),
               (i >= 15), $sformatf("sat_edge_%0d", i)));
    apply(mk(0, 0, 1, 4'h0, 4'h0, 4'hF, 1, 0, 0, 0, "sat_clr"));
    apply(mk(0, 1, 0, 4'h0, 4'h0, 4'hF, 1, 0, 1, 0, "after_sat_clr"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nor_gate.md
NOR_GATE -- requirements
Module: nor_gate

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of operands a, b and outputs y, y_q.
REQ-002 Parameter: CNT_W, default 16, width of the all-NOR event counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: a  input  WIDTH  operand A.
REQ-006 Port: b  input  WIDTH  operand B.
REQ-007 Port: en  input  1  capture enable for registered outputs and counter.
REQ-008 Port: clr  input  1  synchronous clear of counter and sticky flag, active-high.
REQ-009 Port: y  output  WIDTH  combinational bitwise NOR of a and b.
REQ-010 Port: y_q  output  WIDTH  registered copy of y.
REQ-011 Port: y_all  output  1  registered; 1 when every bit of y is 1, i.e. a and b both all-zero.
REQ-012 Port: chg  output  1  registered one-cycle pulse; y_q changed value on the last capture.
REQ-013 Port: cnt  output  CNT_W  saturating count of captures with y all-ones.
REQ-014 Port: sat  output  1  sticky flag; cnt reached all-ones.

Function
REQ-015 y SHALL equal ~(a | b) per bit, purely combinational, zero cycles latency, independent of clk, rst, en.
REQ-016 y SHALL follow the truth table per bit: 00->1, 01->0, 10->0, 11->0.
REQ-017 On a rising edge with rst=0 and en=1, y_q SHALL load y and y_all SHALL load the AND-reduction of y.
REQ-018 With rst=0 and en=0, y_q and y_all SHALL hold; chg SHALL be 0 on the next cycle.
REQ-019 chg SHALL be 1 for exactly one cycle after an enabled capture where the new y_q differs from the old y_q, else 0.
REQ-020 On an enabled capture with the AND-reduction of y equal to 1, cnt SHALL increment by 1 unless all-ones.
REQ-021 cnt SHALL saturate at 2^CNT_W-1 with no wrap; sat SHALL become 1 on the edge cnt becomes all-ones and remain 1.
REQ-022 clr=1 (rst=0) SHALL set cnt=0 and sat=0 on the next edge, taking priority over an increment in the same cycle; y_q, y_all, chg SHALL be unaffected by clr.
REQ-023 X/unknown inputs are not supported; inputs are stable around the clock edge.

Reset
REQ-024 rst=1 at a rising edge SHALL set y_q=all-ones, y_all=1, chg=0, cnt=0, sat=0, overriding en and clr.
REQ-025 Reset values correspond to inputs a=b=0; leaving reset with a=b=0 and en=1 SHALL produce no chg pulse.
REQ-026 rst asserted mid-operation SHALL discard the in-progress capture; y SHALL remain combinational during reset.

Verification
REQ-027 WIDTH=1, apply a,b = 00,01,10,11 at 5-time-unit steps -> y = 1,0,0,0 immediately after each settle.
REQ-028 Reset, then en=1 with a=0,b=1 -> next edge y_q=0, y_all=0, chg=1 one cycle, then chg=0 while inputs are held.
REQ-029 en=1, a=b=0 held 5 edges after reset -> cnt=5, chg=0 throughout; set en=0 -> cnt holds at 5.
REQ-030 CNT_W=4, a=b=0, en=1 for 20 edges -> cnt stops at 15, sat=1 from the 15th edge; clr=1 -> cnt=0, sat=0 next edge.
REQ-031 WIDTH=4, a=4'b0101, b=4'b0011 -> y=4'b1000, y_all=0 after capture; a=b=0 -> y=4'b1111, y_all=1.
REQ-032 rst=1 asserted in the same cycle as en=1, clr=1, a=1 -> y_q=all-ones, cnt=0, chg=0 after that edge.
